// File: rtl/pipe_trace_pkg.sv
// Shared types and constants for the pipeline trace monitor: halt/NOP encodings,
// monitor FSM states and the 32-bit branch trace entry layout.
package pipe_trace_pkg;

  localparam int TRACE_XLEN = 32;

  localparam logic [TRACE_XLEN-1:0] HALT_INSTR = 32'h0000_006F;  // jal x0, 0
  localparam logic [TRACE_XLEN-1:0] NOP_INSTR  = 32'h0000_0000;  // pipeline bubble

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  typedef struct packed {
    logic [TRACE_XLEN-1:0] pc;
    logic [TRACE_XLEN-1:0] target;
    logic                  taken;
  } trace_entry_t;

endpackage

// File: rtl/trace_fifo.sv
// Circular branch-trace buffer with show-ahead head, registered flags and sticky overflow.
// TRACE_OVERWRITE_EN: when defined a push into a full buffer replaces the oldest entry.
module trace_fifo
  import pipe_trace_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  trace_entry_t           wdata,
  output trace_entry_t           rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  trace_entry_t  mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [AW:0]   count_q, count_d;
  logic          full_q, full_d, empty_q, empty_d, ovf_q, ovf_d;
  logic          pop_ok_s, wr_en_s, head_adv_s;

  // Pointer, occupancy and overflow next-state; clear overrides everything.
  always_comb begin
    pop_ok_s = pop && !empty_q;
`ifdef TRACE_OVERWRITE_EN
    wr_en_s    = push;
    head_adv_s = pop_ok_s || (push && full_q);
`else
    wr_en_s    = push && (!full_q || pop_ok_s);
    head_adv_s = pop_ok_s;
`endif
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (head_adv_s) begin
      head_d = head_q + AW'(1);
    end else begin
      head_d = head_q;
    end
    if (wr_en_s) begin
      tail_d = tail_q + AW'(1);
    end else begin
      tail_d = tail_q;
    end
    if (wr_en_s && !head_adv_s) begin
      count_d = count_q + (AW+1)'(1);
    end else if (!wr_en_s && head_adv_s) begin
      count_d = count_q - (AW+1)'(1);
    end else begin
      count_d = count_q;
    end
    if (push && full_q && !pop_ok_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
    if (clear) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      ovf_d = ovf_d;
    end
    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == (AW+1)'(0));
  end

  // Control state registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      ovf_q   <= ovf_d;
    end
  end

  // Entry storage; contents are only observable through a valid head.
  always_ff @(posedge clock) begin
    if (wr_en_s && !clear) begin
      mem_q[tail_q] <= wdata;
    end
  end

  assign rdata    = empty_q ? '0 : mem_q[head_q];
  assign count    = count_q;
  assign full     = full_q;
  assign empty    = empty_q;
  assign overflow = ovf_q;

endmodule

// File: rtl/pipe_trace_monitor.sv
// Per-cycle pipeline observer: branch trace buffer, saturating perf counters, halt detector.
// TRACE_OVERWRITE_EN selects overwrite-oldest behaviour of the trace buffer when full.
module pipe_trace_monitor
  import pipe_trace_pkg::*;
#(
  parameter int XLEN        = TRACE_XLEN,
  parameter int DEPTH       = 16,
  parameter int HALT_REPEAT = 4,
  parameter int CNT_W       = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   clear,
  input  logic [XLEN-1:0]        pc,
  input  logic [XLEN-1:0]        if_instr,
  input  logic                   wb_valid,
  input  logic [XLEN-1:0]        wb_instr,
  input  logic                   br_valid,
  input  logic                   br_taken,
  input  logic [XLEN-1:0]        br_pc,
  input  logic [XLEN-1:0]        br_target,
  input  logic                   rd_ready,
  output logic                   rd_valid,
  output logic [XLEN-1:0]        rd_pc,
  output logic [XLEN-1:0]        rd_target,
  output logic                   rd_taken,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow,
  output logic                   halted,
  output logic [CNT_W-1:0]       cycle_cnt,
  output logic [CNT_W-1:0]       retired_cnt,
  output logic [CNT_W-1:0]       branch_cnt,
  output logic [CNT_W-1:0]       taken_cnt
);

  localparam int SW = $clog2(HALT_REPEAT + 1);

  state_e           state_q, state_d;
  logic [XLEN-1:0]  pc_prev_q;
  logic [SW-1:0]    stable_q, stable_d;
  logic [CNT_W-1:0] cyc_q, cyc_d, ret_q, ret_d, br_q, br_d, tk_q, tk_d;
  logic             halted_q;
  logic             run_s, push_s;
  trace_entry_t     wentry_s, head_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != {CNT_W{1'b1}})) begin
      return v + CNT_W'(1);
    end else begin
      return v;
    end
  endfunction

  // FSM next state, halt stability tracking and counter updates.
  always_comb begin
    run_s    = (state_q == ST_RUN);
    state_d  = state_q;
    stable_d = '0;
    if (run_s && (if_instr == HALT_INSTR) && (pc == pc_prev_q)) begin
      stable_d = stable_q + SW'(1);
    end else begin
      stable_d = '0;
    end
    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_RUN;
        else        state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (!enable)                           state_d = ST_IDLE;
        else if (stable_d == SW'(HALT_REPEAT)) state_d = ST_HALTED;
        else                                   state_d = ST_RUN;
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_IDLE;
    endcase
    cyc_d = sat_inc(cyc_q, run_s);
    ret_d = sat_inc(ret_q, run_s && wb_valid && (wb_instr != NOP_INSTR));
    br_d  = sat_inc(br_q,  run_s && br_valid);
    tk_d  = sat_inc(tk_q,  run_s && br_valid && br_taken);
    if (clear) begin
      state_d  = ST_IDLE;
      stable_d = '0;
      cyc_d    = '0;
      ret_d    = '0;
      br_d     = '0;
      tk_d     = '0;
    end else begin
      state_d = state_d;
    end
  end

  // FSM, halt tracker and counter registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      pc_prev_q <= '0;
      stable_q  <= '0;
      halted_q  <= 1'b0;
      cyc_q     <= '0;
      ret_q     <= '0;
      br_q      <= '0;
      tk_q      <= '0;
    end else begin
      state_q   <= state_d;
      pc_prev_q <= pc;
      stable_q  <= stable_d;
      halted_q  <= (state_d == ST_HALTED);
      cyc_q     <= cyc_d;
      ret_q     <= ret_d;
      br_q      <= br_d;
      tk_q      <= tk_d;
    end
  end

  assign push_s   = br_valid && run_s;
  assign wentry_s = '{pc: br_pc, target: br_target, taken: br_taken};

  trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .clear    (clear),
    .push     (push_s),
    .pop      (rd_ready),
    .wdata    (wentry_s),
    .rdata    (head_s),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .overflow (overflow)
  );

  assign rd_valid    = !empty;
  assign rd_pc       = head_s.pc;
  assign rd_target   = head_s.target;
  assign rd_taken    = head_s.taken;
  assign halted      = halted_q;
  assign cycle_cnt   = cyc_q;
  assign retired_cnt = ret_q;
  assign branch_cnt  = br_q;
  assign taken_cnt   = tk_q;

endmodule

// File: tb/tb_pipe_trace_monitor.sv
// Directed self-checking bench for pipe_trace_monitor (DEPTH=16, HALT_REPEAT=4).
module tb_pipe_trace_monitor;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0, clear = 1'b0;
  logic [31:0] pc = 32'd0, if_instr = 32'd0, wb_instr = 32'd0;
  logic        wb_valid = 1'b0, br_valid = 1'b0, br_taken = 1'b0, rd_ready = 1'b0;
  logic [31:0] br_pc = 32'd0, br_target = 32'd0;
  logic        rd_valid, rd_taken, full, empty, overflow, halted;
  logic [31:0] rd_pc, rd_target;
  logic [4:0]  count;
  logic [31:0] cycle_cnt, retired_cnt, branch_cnt, taken_cnt;

  int n_pass = 0;
  int n_total = 0;

  always #5 clock = ~clock;

  pipe_trace_monitor dut (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear),
    .pc(pc), .if_instr(if_instr), .wb_valid(wb_valid), .wb_instr(wb_instr),
    .br_valid(br_valid), .br_taken(br_taken), .br_pc(br_pc), .br_target(br_target),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_target(rd_target),
    .rd_taken(rd_taken), .count(count), .full(full), .empty(empty), .overflow(overflow),
    .halted(halted), .cycle_cnt(cycle_cnt), .retired_cnt(retired_cnt),
    .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    #12;
    n_total++; if ({rd_valid, full, empty, overflow, halted} !== 5'b00100) $display("FAIL reset_flags got %b exp 00100", {rd_valid, full, empty, overflow, halted}); else n_pass++;
    n_total++; if (count !== 5'd0) $display("FAIL reset_count got %0d exp 0", count); else n_pass++;
    n_total++; if ((cycle_cnt | branch_cnt | taken_cnt | retired_cnt | rd_pc | rd_target) !== 32'd0) $display("FAIL reset_counters got nonzero %h exp 0", cycle_cnt | branch_cnt | taken_cnt | retired_cnt | rd_pc | rd_target); else n_pass++;
    #8 reset = 1'b1;
  endtask

  task automatic test_idle_run();
    enable = 1'b1;
    repeat (11) step();  // first edge enters RUN, next ten count
    n_total++; if (cycle_cnt !== 32'd10) $display("FAIL t1_cycle_cnt got %0d exp 10", cycle_cnt); else n_pass++;
    n_total++; if (branch_cnt !== 32'd0) $display("FAIL t1_branch_cnt got %0d exp 0", branch_cnt); else n_pass++;
    n_total++; if ({empty, halted} !== 2'b10) $display("FAIL t1_empty_halted got %b exp 10", {empty, halted}); else n_pass++;
  endtask

  task automatic test_branch_trace();
    logic [31:0] exp_pc [3] = '{32'd4, 32'd12, 32'd56};
    logic [31:0] exp_tg [3] = '{32'h40, 32'h80, 32'hc0};
    logic        exp_tk [3] = '{1'b1, 1'b0, 1'b1};
    br_valid = 1'b1; wb_valid = 1'b1; wb_instr = 32'h00a0_0093;
    for (int i = 0; i < 3; i++) begin
      br_pc = exp_pc[i]; br_target = exp_tg[i]; br_taken = exp_tk[i];
      if (i == 1) wb_instr = 32'd0;
      if (i == 2) wb_valid = 1'b0;
      step();
    end
    br_valid = 1'b0; br_taken = 1'b0;
    n_total++; if (count !== 5'd3) $display("FAIL t2_count got %0d exp 3", count); else n_pass++;
    n_total++; if (taken_cnt !== 32'd2) $display("FAIL t2_taken_cnt got %0d exp 2", taken_cnt); else n_pass++;
    n_total++; if (branch_cnt !== 32'd3) $display("FAIL t2_branch_cnt got %0d exp 3", branch_cnt); else n_pass++;
    n_total++; if (retired_cnt !== 32'd1) $display("FAIL t2_retired_cnt got %0d exp 1", retired_cnt); else n_pass++;
    rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_total++; if ({rd_valid, rd_pc, rd_target, rd_taken} !== {1'b1, exp_pc[i], exp_tg[i], exp_tk[i]})
        $display("FAIL t2_pop%0d got pc=%0d tg=%h tk=%b exp pc=%0d tg=%h tk=%b", i, rd_pc, rd_target, rd_taken, exp_pc[i], exp_tg[i], exp_tk[i]);
      else n_pass++;
      step();
    end
    rd_ready = 1'b0;
    n_total++; if ({empty, rd_valid, count} !== {1'b1, 1'b0, 5'd0}) $display("FAIL t2_drained got empty=%b valid=%b count=%0d exp 1 0 0", empty, rd_valid, count); else n_pass++;
  endtask

  task automatic test_overflow();
    logic [31:0] exp_head;
`ifdef TRACE_OVERWRITE_EN
    exp_head = 32'h104;
`else
    exp_head = 32'h100;
`endif
    br_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      br_pc = 32'h100 + 32'(4 * i); br_target = 32'h1000 + 32'(i); br_taken = i[0];
      step();
    end
    br_valid = 1'b0;
    n_total++; if (count !== 5'd16) $display("FAIL t3_count got %0d exp 16", count); else n_pass++;
    n_total++; if ({full, overflow} !== 2'b11) $display("FAIL t3_full_ovf got %b exp 11", {full, overflow}); else n_pass++;
    n_total++; if (rd_pc !== exp_head) $display("FAIL t3_head_pc got %h exp %h", rd_pc, exp_head); else n_pass++;
    clear = 1'b1; step(); clear = 1'b0;
    n_total++; if ({empty, overflow, count} !== {1'b1, 1'b0, 5'd0}) $display("FAIL t3_clear_buf got empty=%b ovf=%b count=%0d exp 1 0 0", empty, overflow, count); else n_pass++;
    n_total++; if ((cycle_cnt | branch_cnt | taken_cnt) !== 32'd0) $display("FAIL t3_clear_cnt got %h exp 0", cycle_cnt | branch_cnt | taken_cnt); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    step();  // IDLE -> RUN
    br_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      br_pc = 32'h200 + 32'(4 * i); step();
    end
    n_total++; if ({count, full, overflow} !== {5'd16, 1'b1, 1'b0}) $display("FAIL t5_fill got count=%0d full=%b ovf=%b exp 16 1 0", count, full, overflow); else n_pass++;
    rd_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      br_pc = 32'h300 + 32'(4 * j);
      exp = 32'h200 + 32'(4 * j);
      n_total++; if (rd_pc !== exp) $display("FAIL t5_pp%0d got %h exp %h", j, rd_pc, exp); else n_pass++;
      step();
    end
    br_valid = 1'b0;
    n_total++; if ({count, full, overflow} !== {5'd16, 1'b1, 1'b0}) $display("FAIL t5_pushpop got count=%0d full=%b ovf=%b exp 16 1 0", count, full, overflow); else n_pass++;
    for (int k = 0; k < 16; k++) begin
      exp = (k < 11) ? 32'h200 + 32'(4 * (k + 5)) : 32'h300 + 32'(4 * (k - 11));
      n_total++; if (rd_pc !== exp) $display("FAIL t5_drain%0d got %h exp %h", k, rd_pc, exp); else n_pass++;
      step();
    end
    rd_ready = 1'b0;
    n_total++; if (empty !== 1'b1) $display("FAIL t5_empty got %b exp 1", empty); else n_pass++;
  endtask

  task automatic test_async_reset();
    clear = 1'b1; step(); clear = 1'b0;
    step();  // IDLE -> RUN, cycle_cnt still 0
    br_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      br_pc = 32'h500 + 32'(4 * i); step();
    end
    br_valid = 1'b0;
    repeat (35) step();
    n_total++; if ({count, cycle_cnt} !== {5'd5, 32'd40}) $display("FAIL t6_pre got count=%0d cyc=%0d exp 5 40", count, cycle_cnt); else n_pass++;
    #2 reset = 1'b0; enable = 1'b0;
    #1;
    n_total++; if ({rd_valid, full, empty, overflow, halted, count} !== {5'b00100, 5'd0}) $display("FAIL t6_flags got %b cnt=%0d exp 00100 0", {rd_valid, full, empty, overflow, halted}, count); else n_pass++;
    n_total++; if ((cycle_cnt | branch_cnt | rd_pc) !== 32'd0) $display("FAIL t6_values got %h exp 0", cycle_cnt | branch_cnt | rd_pc); else n_pass++;
    #2 reset = 1'b1;
  endtask

  task automatic test_halt_and_clear();
    pc = 32'd132; if_instr = 32'h0000_006F; enable = 1'b1;
    repeat (3) step();  // enter RUN, then two stable edges
    pc = 32'd136;
    repeat (4) step();  // change restarts, then three stable edges
    n_total++; if (halted !== 1'b0) $display("FAIL t4_not_yet got %b exp 0", halted); else n_pass++;
    step();
    n_total++; if (halted !== 1'b1) $display("FAIL t4_halted got %b exp 1", halted); else n_pass++;
    n_total++; if (cycle_cnt !== 32'd7) $display("FAIL t4_cycle_cnt got %0d exp 7", cycle_cnt); else n_pass++;
    br_valid = 1'b1; br_pc = 32'h600;
    repeat (3) step();
    br_valid = 1'b0;
    n_total++; if ({halted, empty, cycle_cnt, branch_cnt} !== {2'b11, 32'd7, 32'd0}) $display("FAIL t4_frozen got h=%b e=%b cyc=%0d br=%0d exp 1 1 7 0", halted, empty, cycle_cnt, branch_cnt); else n_pass++;
    enable = 1'b0; clear = 1'b1; step(); clear = 1'b0;
    pc = 32'd0; if_instr = 32'd0;
    n_total++; if ({halted, cycle_cnt} !== {1'b0, 32'd0}) $display("FAIL t6_clear_halt got h=%b cyc=%0d exp 0 0", halted, cycle_cnt); else n_pass++;
    step();
    n_total++; if ({halted, cycle_cnt} !== {1'b0, 32'd0}) $display("FAIL t6_idle_after got h=%b cyc=%0d exp 0 0", halted, cycle_cnt); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_idle_run();
    test_branch_trace();
    test_overflow();
    test_back_to_back();
    test_async_reset();
    test_halt_and_clear();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
